eco_sweep_ctrl: RTL and testbench

Sequencer that exhaustively verifies an ECO-patched combinational gate block (e.g. the 4-bit `a`,`b` → `y` netlists) against a golden reference model. It drives every `{a,b}` vector in turn, waits a settle interval, compares the patched block's output with the reference output under a bit mask, and reports a mismatch count and the first failing vector. It sits in the ECO bring-up harness between the patched netlist instance and its golden model.

---
 rtl/eco_pkg.sv | 17 +
 rtl/eco_vec_gen.sv | 54 +++++
 rtl/eco_sweep_ctrl.sv | 154 +++++++++++++++
 tb/tb_eco_sweep_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/eco_pkg.sv
// Shared types and helpers for the ECO sweep controller.
package eco_pkg;

  // Sweep sequencer states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    CMP  = 2'd2,
    DONE = 2'd3
  } eco_state_t;

  // Number of {a,b} vectors for an operand width w: 2^(2w).
  function automatic int eco_nvec(input int w);
    return int'(32'd1 << (2 * w));
  endfunction

endpackage

// File: rtl/eco_vec_gen.sv
// Vector index register and settle down-counter for the ECO sweep.
// load restarts at vector 0, step advances to the next vector (wrapping to 0
// after the last one), dec counts the settle interval down, clr parks at 0.
module eco_vec_gen
  import eco_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clr,
  input  logic           load,
  input  logic           step,
  input  logic           dec,
  output logic [2*W-1:0] v,
  output logic           last,
  output logic           settled
);

  localparam int VW   = 2 * W;
  localparam int CTRW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [VW-1:0]   V_ONE  = {{(VW-1){1'b0}}, 1'b1};
  localparam logic [VW-1:0]   V_LAST = VW'(eco_nvec(W) - 1);
  localparam logic [CTRW-1:0] RELOAD = CTRW'(SETTLE - 1);
  localparam logic [CTRW-1:0] C_ONE  = {{(CTRW-1){1'b0}}, 1'b1};

  logic [VW-1:0]   v_r;
  logic [CTRW-1:0] cnt_r;

  // Index and settle counter update; the index wraps to 0 after the last vector.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      v_r   <= {VW{1'b0}};
      cnt_r <= {CTRW{1'b0}};
    end else if (load) begin
      v_r   <= {VW{1'b0}};
      cnt_r <= RELOAD;
    end else if (step) begin
      v_r   <= v_r + V_ONE;
      cnt_r <= RELOAD;
    end else if (dec) begin
      cnt_r <= cnt_r - C_ONE;
    end else begin
      v_r   <= v_r;
      cnt_r <= cnt_r;
    end
  end

  assign v       = v_r;
  assign last    = (v_r == V_LAST);
  assign settled = (cnt_r == {CTRW{1'b0}});

endmodule

// File: rtl/eco_sweep_ctrl.sv
// Exhaustive sweep of a patched combinational block against its golden model:
// drives every {a,b}, waits SETTLE cycles, compares under y_mask and keeps a
// mismatch count plus the first failing vector.
module eco_sweep_ctrl
  import eco_pkg::*;
#(
  parameter int W      = 4,
  parameter int SETTLE = 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           abort,
  input  logic [W-1:0]   y_mask,
  input  logic [W-1:0]   dut_y,
  input  logic [W-1:0]   ref_y,
  output logic [W-1:0]   a_out,
  output logic [W-1:0]   b_out,
  output logic           busy,
  output logic           done,
  output logic           pass,
  output logic [2*W:0]   mism_cnt,
  output logic [2*W-1:0] first_fail_vec,
  output logic           first_fail_valid
);

  localparam int VW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};

  eco_state_t    state_r, state_s;
  logic          load_s, step_s, dec_s, clr_s, cmp_en_s;
  logic          mism_s, last_s, settled_s;
  logic [VW-1:0] vec_idx_s;

  logic          busy_r, done_r, pass_r, ffv_valid_r;
  logic [CW-1:0] mism_cnt_r;
  logic [VW-1:0] ffv_r;

  eco_vec_gen #(.W(W), .SETTLE(SETTLE)) u_vec_gen (
    .clk     (clk),
    .rst     (rst),
    .clr     (clr_s),
    .load    (load_s),
    .step    (step_s),
    .dec     (dec_s),
    .v       (vec_idx_s),
    .last    (last_s),
    .settled (settled_s)
  );

  assign mism_s = (((dut_y ^ ref_y) & y_mask) != {W{1'b0}});

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state and vector-generator control; abort wins over the compare.
  always_comb begin
    state_s  = state_r;
    load_s   = 1'b0;
    step_s   = 1'b0;
    dec_s    = 1'b0;
    clr_s    = 1'b0;
    cmp_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_s = WAIT;
          load_s  = 1'b1;
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (abort) begin
          state_s = IDLE;
          clr_s   = 1'b1;
        end else if (settled_s) begin
          state_s = CMP;
        end else begin
          dec_s = 1'b1;
        end
      end
      CMP: begin
        if (abort) begin
          state_s = IDLE;
          clr_s   = 1'b1;
        end else begin
          cmp_en_s = 1'b1;
          step_s   = 1'b1;
          state_s  = last_s ? DONE : WAIT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
        clr_s   = 1'b1;
      end
    endcase
  end

  // Result and status registers; status flags follow the next state so they
  // change on the same edge as the state itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pass_r      <= 1'b0;
      ffv_valid_r <= 1'b0;
      mism_cnt_r  <= {CW{1'b0}};
      ffv_r       <= {VW{1'b0}};
    end else begin
      busy_r <= (state_s == WAIT) || (state_s == CMP);
      done_r <= (state_s == DONE);
      if (load_s) begin
        pass_r      <= 1'b0;
        ffv_valid_r <= 1'b0;
        mism_cnt_r  <= {CW{1'b0}};
        ffv_r       <= {VW{1'b0}};
      end else if (cmp_en_s) begin
        if (mism_s) begin
          mism_cnt_r <= mism_cnt_r + CNT_ONE;
          if (!ffv_valid_r) begin
            ffv_valid_r <= 1'b1;
            ffv_r       <= vec_idx_s;
          end
        end
        if (last_s) begin
          pass_r <= (mism_cnt_r == {CW{1'b0}}) && !mism_s;
        end
      end else if (clr_s) begin
        pass_r <= 1'b0;
      end
    end
  end

  assign a_out            = vec_idx_s[VW-1:W];
  assign b_out            = vec_idx_s[W-1:0];
  assign busy             = busy_r;
  assign done             = done_r;
  assign pass             = pass_r;
  assign mism_cnt         = mism_cnt_r;
  assign first_fail_vec   = ffv_r;
  assign first_fail_valid = ffv_valid_r;

endmodule

// File: tb/tb_eco_sweep_ctrl.sv
// Self-checking bench for eco_sweep_ctrl: a W=4/SETTLE=1 instance against a
// modelled patched netlist with injectable faults, and a W=2/SETTLE=3 instance
// for settle timing and vector order.
module tb_eco_sweep_ctrl;

  typedef struct packed {
    logic [8:0] mism;
    logic [7:0] ffv;
    logic       ffvalid;
    logic       pass;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic [3:0] y_mask, dut_y, ref_y, a_out, b_out;
  logic       busy, done, pass, first_fail_valid;
  logic [8:0] mism_cnt;
  logic [7:0] first_fail_vec;

  logic       start2;
  logic [1:0] y_mask2, dut_y2, ref_y2, a2, b2;
  logic       busy2, done2, pass2, ffvalid2;
  logic [4:0] mism2;
  logic [3:0] ffv2;

  int   fault_mode = 0;
  int   n_vec = 0;
  int   n_miscmp = 0;
  exp_t sb_q[$];
  logic [3:0] vq[$];

  function automatic logic [3:0] gold4(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] s;
    s = a + b;
    return s ^ (a & ~b);
  endfunction

  function automatic logic [1:0] gold2(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] s;
    s = a + b;
    return s ^ (a & ~b);
  endfunction

  assign ref_y  = gold4(a_out, b_out) ^
                  (((fault_mode == 1) && (a_out == 4'h3) && (b_out == 4'h5)) ? 4'b0010 : 4'b0000);
  assign dut_y  = gold4(a_out, b_out) & ((fault_mode == 2) ? 4'b1110 : 4'b1111);
  assign ref_y2 = gold2(a2, b2);
  assign dut_y2 = gold2(a2, b2);

  eco_sweep_ctrl #(.W(4), .SETTLE(1)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .y_mask(y_mask),
    .dut_y(dut_y), .ref_y(ref_y), .a_out(a_out), .b_out(b_out), .busy(busy),
    .done(done), .pass(pass), .mism_cnt(mism_cnt), .first_fail_vec(first_fail_vec),
    .first_fail_valid(first_fail_valid)
  );

  eco_sweep_ctrl #(.W(2), .SETTLE(3)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(1'b0), .y_mask(y_mask2),
    .dut_y(dut_y2), .ref_y(ref_y2), .a_out(a2), .b_out(b2), .busy(busy2),
    .done(done2), .pass(pass2), .mism_cnt(mism2), .first_fail_vec(ffv2),
    .first_fail_valid(ffvalid2)
  );

  // Expected results over the first 'limit' vectors for a fault mode and mask.
  function automatic exp_t model(input int mode, input logic [3:0] mask, input int limit);
    exp_t r;
    logic [3:0] a, b, g, ry, dy;
    r = '0;
    for (int v = 0; v < limit; v++) begin
      a  = v[7:4];
      b  = v[3:0];
      g  = gold4(a, b);
      ry = (mode == 1 && v == 32'h35) ? (g ^ 4'b0010) : g;
      dy = (mode == 2) ? (g & 4'b1110) : g;
      if (((dy ^ ry) & mask) != 4'b0000) begin
        r.mism = r.mism + 9'd1;
        if (!r.ffvalid) begin
          r.ffvalid = 1'b1;
          r.ffv     = v[7:0];
        end
      end
    end
    r.pass = (r.mism == 9'd0);
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pulse start so that it is sampled on the next edge (edge 0 of the sweep).
  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Wait for done; returns the edge number it rose on, or -1 on timeout.
  task automatic wait_done(input int budget, input int from_edge, output int edge_no);
    int e;
    e = from_edge;
    edge_no = -1;
    for (int i = 0; i < budget; i++) begin
      tick();
      e++;
      if (done === 1'b1) begin
        edge_no = e;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    if ({busy, done, pass, first_fail_valid, mism_cnt, first_fail_vec, a_out, b_out} !== 29'd0) begin
      n_miscmp++;
      $display("FAIL reset_outputs got busy=%0b done=%0b pass=%0b mism=%0d ffv=%0h a=%0h b=%0h required all 0",
               busy, done, pass, mism_cnt, first_fail_vec, a_out, b_out);
    end
    n_vec++;
    if ({busy2, done2, pass2, ffvalid2, mism2, ffv2, a2, b2} !== 17'd0) begin
      n_miscmp++;
      $display("FAIL reset_outputs2 got nonzero outputs on W=2 instance");
    end
    n_vec++;
    rst = 1'b0;
    tick();
  endtask

  // Full sweep with a given fault mode and mask; checks timing and results.
  task automatic test_sweep(input string nm, input int mode, input logic [3:0] mask);
    exp_t ex;
    int   e;
    fault_mode = mode;
    y_mask     = mask;
    sb_q.push_back(model(mode, mask, 256));
    do_start();
    if (busy !== 1'b1) begin n_miscmp++; $display("FAIL %s_busy_rise got %0b required 1", nm, busy); end
    n_vec++;
    wait_done(600, 0, e);
    if (e !== 512) begin n_miscmp++; $display("FAIL %s_done_edge got %0d required 512", nm, e); end
    n_vec++;
    if (busy !== 1'b0) begin n_miscmp++; $display("FAIL %s_busy_fall got %0b required 0", nm, busy); end
    n_vec++;
    ex = sb_q.pop_front();
    if (mism_cnt !== ex.mism) begin n_miscmp++; $display("FAIL %s_mism got %0d required %0d", nm, mism_cnt, ex.mism); end
    n_vec++;
    if (first_fail_valid !== ex.ffvalid) begin
      n_miscmp++; $display("FAIL %s_ffvalid got %0b required %0b", nm, first_fail_valid, ex.ffvalid);
    end
    n_vec++;
    if (first_fail_vec !== ex.ffv) begin
      n_miscmp++; $display("FAIL %s_ffvec got %0h required %0h", nm, first_fail_vec, ex.ffv);
    end
    n_vec++;
    tick();
    if (done !== 1'b0) begin n_miscmp++; $display("FAIL %s_done_pulse got %0b required 0", nm, done); end
    n_vec++;
    if (pass !== ex.pass) begin n_miscmp++; $display("FAIL %s_pass got %0b required %0b", nm, pass, ex.pass); end
    n_vec++;
    if ({a_out, b_out} !== 8'h00) begin n_miscmp++; $display("FAIL %s_idle_ab got %0h required 0", nm, {a_out, b_out}); end
    n_vec++;
  endtask

  // Abort at edge 100 (CMP exit of vector 49, which must not be counted), then restart.
  task automatic test_abort();
    exp_t ex;
    int   e;
    bit   seen;
    fault_mode = 2;
    y_mask     = 4'h1;
    ex = model(2, 4'h1, 49);
    ex.pass = 1'b0;
    sb_q.push_back(ex);
    do_start();
    repeat (99) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    ex = sb_q.pop_front();
    if ({busy, done, pass} !== 3'b000) begin
      n_miscmp++; $display("FAIL abort_status got busy=%0b done=%0b pass=%0b required 000", busy, done, pass);
    end
    n_vec++;
    if ({a_out, b_out} !== 8'h00) begin n_miscmp++; $display("FAIL abort_ab got %0h required 0", {a_out, b_out}); end
    n_vec++;
    if (mism_cnt !== ex.mism) begin n_miscmp++; $display("FAIL abort_mism got %0d required %0d", mism_cnt, ex.mism); end
    n_vec++;
    if ({first_fail_valid, first_fail_vec} !== {ex.ffvalid, ex.ffv}) begin
      n_miscmp++; $display("FAIL abort_ffv got %0b/%0h required %0b/%0h", first_fail_valid, first_fail_vec, ex.ffvalid, ex.ffv);
    end
    n_vec++;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    if (seen) begin n_miscmp++; $display("FAIL abort_quiet got done/busy activity required none"); end
    n_vec++;
    fault_mode = 0;
    y_mask     = 4'hF;
    sb_q.push_back(model(0, 4'hF, 256));
    do_start();
    if ({first_fail_valid, mism_cnt} !== 10'd0) begin
      n_miscmp++; $display("FAIL restart_clear got ffvalid=%0b mism=%0d required 0", first_fail_valid, mism_cnt);
    end
    n_vec++;
    wait_done(600, 0, e);
    if (e !== 512) begin n_miscmp++; $display("FAIL restart_done_edge got %0d required 512", e); end
    n_vec++;
    ex = sb_q.pop_front();
    tick();
    if ({pass, mism_cnt} !== {ex.pass, ex.mism}) begin
      n_miscmp++; $display("FAIL restart_result got pass=%0b mism=%0d required %0b/%0d", pass, mism_cnt, ex.pass, ex.mism);
    end
    n_vec++;
  endtask

  task automatic test_reset_mid();
    fault_mode = 2;
    y_mask     = 4'h1;
    do_start();
    repeat (299) tick();
    rst = 1'b1;
    tick();
    if ({busy, done, pass, first_fail_valid, mism_cnt, first_fail_vec, a_out, b_out} !== 29'd0) begin
      n_miscmp++;
      $display("FAIL reset_mid got busy=%0b mism=%0d ffv=%0h a=%0h b=%0h required all 0",
               busy, mism_cnt, first_fail_vec, a_out, b_out);
    end
    n_vec++;
    rst = 1'b0;
    tick();
  endtask

  // start while busy and start during the done cycle are both ignored.
  task automatic test_back_to_back();
    int e;
    fault_mode = 0;
    y_mask     = 4'hF;
    do_start();
    repeat (49) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(600, 50, e);
    if (e !== 512) begin n_miscmp++; $display("FAIL busy_start_done_edge got %0d required 512", e); end
    n_vec++;
    start = 1'b1;
    tick();
    start = 1'b0;
    if (busy !== 1'b0) begin n_miscmp++; $display("FAIL done_cycle_start got busy=%0b required 0", busy); end
    n_vec++;
    tick();
    if ({busy, done} !== 2'b00) begin n_miscmp++; $display("FAIL done_cycle_start2 got %0b required 00", {busy, done}); end
    n_vec++;
  endtask

  // W=2, SETTLE=3: each vector occupies 4 cycles, order 0..F, done at edge 64.
  task automatic test_settle3();
    logic [3:0] ex;
    y_mask2 = 2'b11;
    for (int n = 0; n < 16; n++) vq.push_back(4'(n));
    start2 = 1'b1;
    tick();
    start2 = 1'b0;
    for (int n = 0; n < 16; n++) begin
      ex = vq.pop_front();
      for (int k = 0; k < 4; k++) begin
        if ({a2, b2} !== ex || done2 !== 1'b0) begin
          n_miscmp++;
          $display("FAIL settle3_vec edge %0d got ab=%0h done=%0b required ab=%0h done=0", n * 4 + k, {a2, b2}, done2, ex);
        end
        n_vec++;
        tick();
      end
    end
    if ({done2, busy2} !== 2'b10) begin n_miscmp++; $display("FAIL settle3_done got done/busy=%0b required 10", {done2, busy2}); end
    n_vec++;
    tick();
    if ({pass2, mism2, a2, b2} !== {1'b1, 5'd0, 4'h0}) begin
      n_miscmp++; $display("FAIL settle3_result got pass=%0b mism=%0d ab=%0h required 1/0/0", pass2, mism2, {a2, b2});
    end
    n_vec++;
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; y_mask = 4'hF;
    start2 = 1'b0; y_mask2 = 2'b11;
    test_reset();
    test_sweep("clean", 0, 4'hF);
    test_sweep("single_fault", 1, 4'hF);
    test_sweep("mask_fault", 1, 4'b1101);
    test_sweep("stuck_y0", 2, 4'h1);
    test_abort();
    test_reset_mid();
    test_back_to_back();
    test_settle3();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
    $finish;
  end

endmodule
